// File: rtl/minesweeper_pkg.sv
// Shared minesweeper types and constants: cell visibility, cell contents,
// tile geometry and the 4:4:4 palette used by the field renderer.
package minesweeper_pkg;

    typedef enum logic [1:0] {
        CELL_CLOSE = 2'd0,
        CELL_OPEN  = 2'd1,
        CELL_FLAG  = 2'd2
    } vis_state_t;

    localparam logic [3:0] CELL_EMPTY = 4'd0;
    localparam logic [3:0] CELL_MINE  = 4'd10;
    localparam logic [3:0] GLYPH_FLAG = 4'd11;

    localparam int TILE_SIZE_LOG2 = 4;

    localparam logic [11:0] COL_BLACK   = 12'h000;
    localparam logic [11:0] COL_OUTSIDE = 12'h222;
    localparam logic [11:0] COL_GRID    = 12'h444;
    localparam logic [11:0] COL_CLOSED  = 12'h888;
    localparam logic [11:0] COL_OPEN    = 12'hCCC;
    localparam logic [11:0] COL_FLAG    = 12'hF00;
    localparam logic [11:0] COL_CURSOR  = 12'hFF0;
    localparam logic [11:0] COL_ERROR   = 12'hF0F;
    localparam logic [11:0] COL_MINE    = 12'h000;

    function automatic logic [11:0] digit_colour(input logic [3:0] count);
        case (count)
            4'd1:    digit_colour = 12'h00F;
            4'd2:    digit_colour = 12'h080;
            4'd3:    digit_colour = 12'hF00;
            default: digit_colour = 12'h008;
        endcase
    endfunction

endpackage

// File: rtl/tile_glyph_rom.sv
// Registered 16x16 glyph lookup: digits 1-9 drawn as 2x2 dots on a 3x3 grid,
// a mine as a rounded square and a flag as a pole with a pennant.
module tile_glyph_rom
    import minesweeper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] glyph_i,
    input  logic [3:0] row_i,
    input  logic [3:0] col_i,
    output logic       pix_o
);

    logic pix_d, pix_q;

    always_comb begin
        pix_d = 1'b0;
        if (glyph_i >= 4'd1 && glyph_i <= 4'd9) begin
            for (int k = 0; k < 9; k++) begin
                if (glyph_i > 4'(k) &&
                    (row_i == 4'(3 + 4 * (k / 3)) || row_i == 4'(4 + 4 * (k / 3))) &&
                    (col_i == 4'(3 + 4 * (k % 3)) || col_i == 4'(4 + 4 * (k % 3))))
                    pix_d = 1'b1;
            end
        end else if (glyph_i == CELL_MINE) begin
            pix_d = row_i >= 4'd4 && row_i <= 4'd11 && col_i >= 4'd4 && col_i <= 4'd11 &&
                    !((row_i == 4'd4 || row_i == 4'd11) && (col_i == 4'd4 || col_i == 4'd11));
        end else if (glyph_i == GLYPH_FLAG) begin
            pix_d = (col_i == 4'd8 && row_i >= 4'd3 && row_i <= 4'd12) ||
                    (row_i >= 4'd3 && row_i <= 4'd7 && col_i >= 4'd4 && col_i <= 4'd7);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) pix_q <= 1'b0;
        else      pix_q <= pix_d;
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/field_renderer.sv
// Three-stage pixel pipeline rendering the minesweeper field: tile coordinates,
// cell/glyph lookup, colour select. Frame parameters latch on frame_start_i.
module field_renderer
    import minesweeper_pkg::*;
#(
    parameter int MAX_CELL_WIDTH  = 30,
    parameter int MAX_CELL_HEIGHT = 16,
    parameter int ORIGIN_X        = 160,
    parameter int ORIGIN_Y        = 172,
    parameter int BLINK_FRAMES    = 30
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [10:0]                          pixel_x_i,
    input  logic [9:0]                           pixel_y_i,
    input  logic                                 pixel_valid_i,
    input  logic                                 frame_start_i,
    input  logic [3:0]                           cells_state_i [MAX_CELL_WIDTH][MAX_CELL_HEIGHT],
    input  vis_state_t                           cells_vis_i   [MAX_CELL_WIDTH][MAX_CELL_HEIGHT],
    input  logic [$clog2(MAX_CELL_WIDTH)-1:0]    player_x_i,
    input  logic [$clog2(MAX_CELL_HEIGHT)-1:0]   player_y_i,
    input  logic [$clog2(MAX_CELL_WIDTH+1)-1:0]  field_width_i,
    input  logic [$clog2(MAX_CELL_HEIGHT+1)-1:0] field_height_i,
    output logic [11:0]                          rgb_o,
    output logic                                 rgb_valid_o
);

    localparam int XW = $clog2(MAX_CELL_WIDTH);
    localparam int YW = $clog2(MAX_CELL_HEIGHT);
    localparam int WW = $clog2(MAX_CELL_WIDTH + 1);
    localparam int HW = $clog2(MAX_CELL_HEIGHT + 1);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int CW = 12 - TILE_SIZE_LOG2;
    localparam logic [11:0] ORG_X  = 12'(ORIGIN_X);
    localparam logic [11:0] ORG_Y  = 12'(ORIGIN_Y);
    localparam logic [CW-1:0] MAX_CX = CW'(MAX_CELL_WIDTH);
    localparam logic [CW-1:0] MAX_CY = CW'(MAX_CELL_HEIGHT);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [WW-1:0] width_d, width_q;
    logic [HW-1:0] height_d, height_q;
    logic [XW-1:0] player_x_d, player_x_q;
    logic [YW-1:0] player_y_d, player_y_q;
    logic [BW-1:0] blink_cnt_d, blink_cnt_q;
    logic          blink_phase_d, blink_phase_q;

    always_comb begin
        width_d       = width_q;
        height_d      = height_q;
        player_x_d    = player_x_q;
        player_y_d    = player_y_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start_i) begin
            width_d    = field_width_i;
            height_d   = field_height_i;
            player_x_d = player_x_i;
            player_y_d = player_y_i;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Stage 1: the sign bit of the 12-bit difference flags pixels left of / above the field
    logic [11:0]   dx, dy;
    logic [CW-1:0] cx_full, cy_full;
    logic          in_field, border;

    logic          s1_valid_d, s1_valid_q, s1_in_field_d, s1_in_field_q, s1_cursor_d, s1_cursor_q;
    logic [XW-1:0] s1_cx_d, s1_cx_q;
    logic [YW-1:0] s1_cy_d, s1_cy_q;
    logic [3:0]    s1_off_x_d, s1_off_x_q, s1_off_y_d, s1_off_y_q;

    always_comb begin
        dx       = {1'b0, pixel_x_i} - ORG_X;
        dy       = {2'b0, pixel_y_i} - ORG_Y;
        cx_full  = dx[11:TILE_SIZE_LOG2];
        cy_full  = dy[11:TILE_SIZE_LOG2];
        in_field = !dx[11] && !dy[11] &&
                   cx_full < CW'(width_q) && cy_full < CW'(height_q) &&
                   cx_full < MAX_CX && cy_full < MAX_CY;
        border   = dx[3:0] == 4'h0 || dx[3:0] == 4'hF || dy[3:0] == 4'h0 || dy[3:0] == 4'hF;

        s1_valid_d    = pixel_valid_i;
        s1_in_field_d = in_field;
        s1_cx_d       = in_field ? cx_full[XW-1:0] : '0;
        s1_cy_d       = in_field ? cy_full[YW-1:0] : '0;
        s1_off_x_d    = dx[3:0];
        s1_off_y_d    = dy[3:0];
        s1_cursor_d   = in_field && blink_phase_q && border &&
                        cx_full == CW'(player_x_q) && cy_full == CW'(player_y_q);
    end

    // Stage 2: live cell read; glyph ROM output lines up with the stage-2 registers
    logic          s2_valid_d, s2_valid_q, s2_in_field_d, s2_in_field_q, s2_cursor_d, s2_cursor_q;
    logic [3:0]    s2_state_d, s2_state_q, s2_off_x_d, s2_off_x_q, s2_off_y_d, s2_off_y_q;
    vis_state_t    s2_vis_d, s2_vis_q;
    logic [3:0]    glyph_idx;
    logic          glyph_pix;

    always_comb begin
        s2_valid_d    = s1_valid_q;
        s2_in_field_d = s1_in_field_q;
        s2_cursor_d   = s1_cursor_q;
        s2_off_x_d    = s1_off_x_q;
        s2_off_y_d    = s1_off_y_q;
        s2_state_d    = cells_state_i[s1_cx_q][s1_cy_q];
        s2_vis_d      = cells_vis_i[s1_cx_q][s1_cy_q];
        glyph_idx     = (s2_vis_d == CELL_FLAG) ? GLYPH_FLAG : s2_state_d;
    end

    tile_glyph_rom u_glyph (
        .clk     (clk),
        .rst     (rst),
        .glyph_i (glyph_idx),
        .row_i   (s1_off_y_q),
        .col_i   (s1_off_x_q),
        .pix_o   (glyph_pix)
    );

    logic [11:0] rgb_d, rgb_q;
    logic        rgb_valid_d, rgb_valid_q;
    logic        grid;

    always_comb begin
        grid        = s2_off_x_q == 4'h0 || s2_off_y_q == 4'h0;
        rgb_valid_d = s2_valid_q;
        rgb_d       = COL_CLOSED;
        if (!s2_valid_q)         rgb_d = COL_BLACK;
        else if (!s2_in_field_q) rgb_d = COL_OUTSIDE;
        else if (s2_cursor_q)    rgb_d = COL_CURSOR;
        else begin
            case (s2_vis_q)
                CELL_OPEN: begin
                    if (s2_state_q > CELL_MINE)       rgb_d = COL_ERROR;
                    else if (!glyph_pix)              rgb_d = COL_OPEN;
                    else if (s2_state_q == CELL_MINE) rgb_d = COL_MINE;
                    else                              rgb_d = digit_colour(s2_state_q);
                end
                CELL_FLAG: rgb_d = grid ? COL_GRID : (glyph_pix ? COL_FLAG : COL_CLOSED);
                default:   rgb_d = grid ? COL_GRID : COL_CLOSED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            width_q       <= '0;
            height_q      <= '0;
            player_x_q    <= '0;
            player_y_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            s1_valid_q    <= 1'b0;
            s1_in_field_q <= 1'b0;
            s1_cursor_q   <= 1'b0;
            s1_cx_q       <= '0;
            s1_cy_q       <= '0;
            s1_off_x_q    <= '0;
            s1_off_y_q    <= '0;
            s2_valid_q    <= 1'b0;
            s2_in_field_q <= 1'b0;
            s2_cursor_q   <= 1'b0;
            s2_state_q    <= CELL_EMPTY;
            s2_vis_q      <= CELL_CLOSE;
            s2_off_x_q    <= '0;
            s2_off_y_q    <= '0;
            rgb_q         <= COL_BLACK;
            rgb_valid_q   <= 1'b0;
        end else begin
            width_q       <= width_d;
            height_q      <= height_d;
            player_x_q    <= player_x_d;
            player_y_q    <= player_y_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            s1_valid_q    <= s1_valid_d;
            s1_in_field_q <= s1_in_field_d;
            s1_cursor_q   <= s1_cursor_d;
            s1_cx_q       <= s1_cx_d;
            s1_cy_q       <= s1_cy_d;
            s1_off_x_q    <= s1_off_x_d;
            s1_off_y_q    <= s1_off_y_d;
            s2_valid_q    <= s2_valid_d;
            s2_in_field_q <= s2_in_field_d;
            s2_cursor_q   <= s2_cursor_d;
            s2_state_q    <= s2_state_d;
            s2_vis_q      <= s2_vis_d;
            s2_off_x_q    <= s2_off_x_d;
            s2_off_y_q    <= s2_off_y_d;
            rgb_q         <= rgb_d;
            rgb_valid_q   <= rgb_valid_d;
        end
    end

    assign rgb_o       = rgb_q;
    assign rgb_valid_o = rgb_valid_q;

endmodule

// File: doc/field_renderer.md
FIELD_RENDERER -- requirements
Module: field_renderer

Interface
REQ-001 Parameters: MAX_CELL_WIDTH, 30, field columns; MAX_CELL_HEIGHT, 16, field rows; ORIGIN_X, 160, field left pixel; ORIGIN_Y, 172, field top pixel; BLINK_FRAMES, 30, frames per cursor blink half-period.
REQ-002 Ports, in this order: clk  in  1  system clock; rst  in  1  reset, synchronous, active-low.
REQ-003 pixel_x_i  in  11  current pixel column; pixel_y_i  in  10  current pixel row; pixel_valid_i  in  1  active-video pixel; frame_start_i  in  1  one-cycle pulse before first pixel of a frame.
REQ-004 cells_state_i  in  4 x [MAX_CELL_WIDTH][MAX_CELL_HEIGHT]  cell content (0 empty, 1-9 neighbour count, 10 mine); cells_vis_i  in  vis_state x same dims  CELL_CLOSE/CELL_OPEN/CELL_FLAG.
REQ-005 player_x_i  in  $clog2(MAX_CELL_WIDTH)  cursor column; player_y_i  in  $clog2(MAX_CELL_HEIGHT)  cursor row; field_width_i, field_height_i  in  same widths  active field size in cells.
REQ-006 rgb_o  out  12  4:4:4 pixel colour (R[11:8] G[7:4] B[3:0]); rgb_valid_o  out  1  rgb_o belongs to an active pixel.

Function
REQ-007 Tiles are 16x16 pixels; cell_x = (pixel_x_i - ORIGIN_X) >> 4, cell_y = (pixel_y_i - ORIGIN_Y) >> 4, tile offsets = low 4 bits of each difference.
REQ-008 Fixed 3-cycle pipeline: stage 1 tile coordinate/in-field compute, stage 2 cell array and glyph lookup, stage 3 colour select; rgb_o/rgb_valid_o correspond to pixel presented 3 cycles earlier, one result per cycle, no stalls.
REQ-009 rgb_valid_o = pixel_valid_i delayed 3 cycles; when delayed valid is 0, rgb_o = 12'h000.
REQ-010 field_width_i, field_height_i, player_x_i, player_y_i sampled into frame registers only on frame_start_i; held constant for the whole frame; cells_state_i/cells_vis_i read live in stage 2.
REQ-011 Out-of-field (pixel_x_i < ORIGIN_X, pixel_y_i < ORIGIN_Y, cell_x >= sampled width or cell_y >= sampled height): rgb_o = 12'h222; no array access with out-of-range index.
REQ-012 CELL_CLOSE: 12'h888, tile offset row 0 or column 0 = 12'h444 (grid line).
REQ-013 CELL_FLAG: as CELL_CLOSE, flag-glyph pixels 12'hF00.
REQ-014 CELL_OPEN: background 12'hCCC; state 0 no glyph; state 1 glyph 12'h00F, 2 12'h080, 3 12'hF00, 4-9 12'h008; state 10 mine glyph 12'h000; states 11-15 whole tile 12'hF0F (error).
REQ-015 Cursor: tile equal to sampled player coordinates, offset row/column 0 or 15, blink phase 1 -> 12'hFF0, overriding REQ-012..014.
REQ-016 Blink counter counts frame_start_i pulses 0..BLINK_FRAMES-1, wraps to 0 and toggles blink phase on wrap.
REQ-017 frame_start_i coincident with pixel_valid_i: pixel uses previous frame registers; new values apply from next cycle.
REQ-018 Arithmetic: subtraction in 12-bit, underflow detected by sign bit, treated as out-of-field; cell coords truncated only after range check.

Reset
REQ-019 rst low at clk edge: pipeline valids 0, rgb_o 12'h000, rgb_valid_o 0, blink counter 0, blink phase 1, sampled width/height/player 0 (all pixels out-of-field until first frame_start_i).
REQ-020 Reset mid-frame discards in-flight pixels; first valid output 3 cycles after first pixel_valid_i following rst release.

Structure
REQ-021 vis_state enum (CELL_CLOSE, CELL_OPEN, CELL_FLAG), cell-content constants (CELL_EMPTY=0, CELL_MINE=10), TILE_SIZE_LOG2=4 and colour constants live in shared package minesweeper_pkg, also imported by game FSM.
REQ-022 Glyph bitmaps in one sub-module tile_glyph_rom: inputs glyph index (0-9 digits, 10 mine, 11 flag), row 4 bits, column 4 bits; output 1-bit pixel, registered (stage 2 latency).

Verification
REQ-023 width 30, height 16, all closed, player (15,8), blink phase 1; pixel (160,172) valid -> 3 cycles later rgb_o 12'h444, rgb_valid_o 1.
REQ-024 pixel (159,200) and pixel (640,200) with width 30 -> rgb_o 12'h222 both; width 10, pixel (330,200) -> 12'h222.
REQ-025 cell (2,3) open state 10 -> mine glyph pixels 12'h000, others 12'hCCC; state 12 -> whole tile 12'hF0F.
REQ-026 player (0,0), 30 frame_start_i pulses -> cursor border toggles 12'hFF0 / 12'h444; change player_x_i mid-frame -> no cursor move until next frame_start_i.
REQ-027 back-to-back valid pixels with rst low for 1 cycle mid-stream -> rgb_valid_o 0 for 3 cycles after release, rgb_o 12'h000, sampled dims 0 -> 12'h222 until frame_start_i.
